// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared types and helpers for the logic_unit_pipe block.
//   LU_OP_W  : opcode width
//   lu_op_e  : the eight bitwise operations
//   lu_eval  : single-bit evaluation of an operation. All ops are bitwise, so
//              applying it per bit position gives the full-width result for
//              any WIDTH.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    localparam int LU_OP_W = 3;

    typedef enum logic [LU_OP_W-1:0] {
        LU_AND  = 3'd0,
        LU_OR   = 3'd1,
        LU_XOR  = 3'd2,
        LU_NOT  = 3'd3,
        LU_NAND = 3'd4,
        LU_NOR  = 3'd5,
        LU_XNOR = 3'd6,
        LU_PASS = 3'd7
    } lu_op_e;

    function automatic logic lu_eval(input lu_op_e op, input logic a, input logic b);
        logic r;
        case (op)
            LU_AND:  r = a & b;
            LU_OR:   r = a | b;
            LU_XOR:  r = a ^ b;
            LU_NOT:  r = ~a;
            LU_NAND: r = ~(a & b);
            LU_NOR:  r = ~(a | b);
            LU_XNOR: r = ~(a ^ b);
            LU_PASS: r = a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_if.sv
// -----------------------------------------------------------------------------
// logic_unit_if
// Operand/opcode input channel and result output channel of logic_unit_pipe.
//   master : operand source and result consumer (drives in_*, out_ready)
//   slave  : the logic unit (drives in_ready, out_*)
// Optional macro LOGIC_UNIT_POPCNT_EN adds out_pop (popcount of out_data).
// -----------------------------------------------------------------------------
interface logic_unit_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_x;
    logic [WIDTH-1:0]   in_y;
    logic [LU_OP_W-1:0] in_op;
    logic               in_acc;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;
    logic               out_par;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [$clog2(WIDTH+1)-1:0] out_pop;

    modport master (
        output in_valid, in_x, in_y, in_op, in_acc, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_par, out_pop
    );
    modport slave (
        input  in_valid, in_x, in_y, in_op, in_acc, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_par, out_pop
    );
`else
    modport master (
        output in_valid, in_x, in_y, in_op, in_acc, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_par
    );
    modport slave (
        input  in_valid, in_x, in_y, in_op, in_acc, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_par
    );
`endif
endinterface

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
// Purely combinational evaluation of one bitwise operation.
//   op     in  opcode
//   a, b   in  operands (b ignored by NOT and PASS)
//   result out op(a, b)
//   zero   out result == 0
//   par    out XOR-reduce of result
//   pop    out popcount of result (only with LOGIC_UNIT_POPCNT_EN)
// -----------------------------------------------------------------------------
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  lu_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef LOGIC_UNIT_POPCNT_EN
    output logic [$clog2(WIDTH+1)-1:0] pop,
`endif
    output logic             par
);

    function automatic logic calc_par(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign result[i] = lu_eval(op, a[i], b[i]);
    end

    assign zero = (result == {WIDTH{1'b0}});
    assign par  = calc_par(result);

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int POP_W = $clog2(WIDTH+1);

    // Count set bits of the result.
    always_comb begin
        pop = {POP_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(result[i]);
        end
    end
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Registered bitwise logic unit with valid/ready handshake, one-deep output
// register, optional accumulator feedback and accepted-operation counter.
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   acc_clr  in   clear accumulator (applied before an acc-mode load)
//   bus      slave modport of logic_unit_if (in_* channel, out_* channel)
//   acc      out  accumulator value
//   op_cnt   out  accepted-operation count (wraps)
// Optional macro LOGIC_UNIT_POPCNT_EN: registers popcount of the result on
// bus.out_pop alongside out_data.
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_clr,
    logic_unit_if.slave      bus,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_cnt
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_zero_r;
    logic             out_par_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] op_cnt_r;

    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] result_s;
    logic             zero_s;
    logic             par_s;

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int POP_W = $clog2(WIDTH+1);
    logic [POP_W-1:0] pop_s;
    logic [POP_W-1:0] out_pop_r;
`endif

    // The output slot is free when empty or being drained this cycle.
    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Operand A: accumulator in acc mode (zeroed by a same-cycle clear), else X.
    always_comb begin
        op_a_s = bus.in_x;
        if (bus.in_acc) begin
            if (acc_clr) begin
                op_a_s = {WIDTH{1'b0}};
            end else begin
                op_a_s = acc_r;
            end
        end else begin
            op_a_s = bus.in_x;
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (lu_op_e'(bus.in_op)),
        .a      (op_a_s),
        .b      (bus.in_y),
        .result (result_s),
        .zero   (zero_s),
`ifdef LOGIC_UNIT_POPCNT_EN
        .pop    (pop_s),
`endif
        .par    (par_s)
    );

    // Output register, accumulator and operation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_zero_r  <= 1'b1;
            out_par_r   <= 1'b0;
            acc_r       <= {WIDTH{1'b0}};
            op_cnt_r    <= {CNT_W{1'b0}};
`ifdef LOGIC_UNIT_POPCNT_EN
            out_pop_r   <= {POP_W{1'b0}};
`endif
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= result_s;
                out_zero_r  <= zero_s;
                out_par_r   <= par_s;
`ifdef LOGIC_UNIT_POPCNT_EN
                out_pop_r   <= pop_s;
`endif
                op_cnt_r    <= op_cnt_r + CNT_W'(1);
            end else if (bus.out_ready) begin
                // Drain: result data is kept, only valid drops.
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            if (accept_s && bus.in_acc) begin
                acc_r <= result_s;
            end else if (acc_clr) begin
                acc_r <= {WIDTH{1'b0}};
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_par   = out_par_r;
`ifdef LOGIC_UNIT_POPCNT_EN
    assign bus.out_pop   = out_pop_r;
`endif
    assign acc           = acc_r;
    assign op_cnt        = op_cnt_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
// Directed bench for logic_unit_pipe (WIDTH=8). Two instances share stimulus:
// u_dut with CNT_W=16 and u_dut_w with CNT_W=2 for counter wrap. A
// transaction-level model tracks the expected state and is compared on every
// negedge; hand-computed literals pin the key results.
// Define LOGIC_UNIT_POPCNT_EN to also exercise out_pop.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic acc_clr = 1'b0;
    logic [W-1:0] acc, acc_w;
    logic [15:0]  op_cnt;
    logic [1:0]   op_cnt_w;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    logic_unit_if #(.WIDTH(W)) bus ();
    logic_unit_if #(.WIDTH(W)) bus_w ();

    assign bus_w.in_valid  = bus.in_valid;
    assign bus_w.in_x      = bus.in_x;
    assign bus_w.in_y      = bus.in_y;
    assign bus_w.in_op     = bus.in_op;
    assign bus_w.in_acc    = bus.in_acc;
    assign bus_w.out_ready = bus.out_ready;

    logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_clr (acc_clr),
        .bus     (bus.slave),
        .acc     (acc),
        .op_cnt  (op_cnt)
    );

    logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) u_dut_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_clr (acc_clr),
        .bus     (bus_w.slave),
        .acc     (acc_w),
        .op_cnt  (op_cnt_w)
    );

    // Reference semantics of each opcode.
    function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            3:       return ~a;
            4:       return ~(a & b);
            5:       return ~(a | b);
            6:       return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state.
    logic        m_valid;
    logic [W-1:0] m_data, m_acc;
    int unsigned m_cnt;
    logic        m_ready;
    logic [W-1:0] m_a, m_res;

    always_comb begin
        m_ready = !m_valid || bus.out_ready;
        m_a     = bus.in_acc ? (acc_clr ? 8'h00 : m_acc) : bus.in_x;
        m_res   = ref_op(int'(bus.in_op), m_a, bus.in_y);
    end

    // Model update: one accepted transaction per edge at most.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_acc   <= 8'h00;
            m_cnt   <= 0;
        end else if (bus.in_valid && m_ready) begin
            m_valid <= 1'b1;
            m_data  <= m_res;
            m_cnt   <= m_cnt + 1;
            if (bus.in_acc) m_acc <= m_res;
            else if (acc_clr) m_acc <= 8'h00;
        end else begin
            if (bus.out_ready) m_valid <= 1'b0;
            if (acc_clr) m_acc <= 8'h00;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("in_ready",  32'(bus.in_ready),  32'(m_ready));
            chk("out_data",  32'(bus.out_data),  32'(m_data));
            chk("out_zero",  32'(bus.out_zero),  32'(m_data == 8'h00));
            chk("out_par",   32'(bus.out_par),   32'($countones(m_data) % 2));
            chk("acc",       32'(acc),           32'(m_acc));
            chk("op_cnt",    32'(op_cnt),        m_cnt % 65536);
            chk("op_cnt_w",  32'(op_cnt_w),      m_cnt % 4);
            chk("out_data_w", 32'(bus_w.out_data), 32'(m_data));
`ifdef LOGIC_UNIT_POPCNT_EN
            chk("out_pop",   32'(bus.out_pop),   32'($countones(m_data)));
`endif
        end
    end

    // Set inputs; operands are randomised when not valid (must not matter).
    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int op, input logic am, input logic cl, input logic ordy);
        bus.in_valid  = v;
        bus.in_x      = v ? x : W'($urandom);
        bus.in_y      = v ? y : W'($urandom);
        bus.in_op     = v ? 3'(op) : 3'($urandom_range(7, 0));
        bus.in_acc    = am;
        acc_clr       = cl;
        bus.out_ready = ordy;
    endtask

    task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int op, input logic am, input logic cl, input logic ordy);
        drive(v, x, y, op, am, cl, ordy);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] tbl [8] = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'hCF, 8'h03, 8'h33, 8'hF0};

    initial begin
        drive(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_zero",  32'(bus.out_zero),  32'd1);
        chk("rst_out_par",   32'(bus.out_par),   32'd0);
        chk("rst_acc",       32'(acc),           32'd0);
        chk("rst_op_cnt",    32'(op_cnt),        32'd0);
        rst_n = 1'b1;

        // All eight ops back-to-back on X=F0, Y=3C.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'hF0, 8'h3C, i, 1'b0, 1'b0, 1'b1);
            chk("ops_data",  32'(bus.out_data),  32'(tbl[i]));
            chk("ops_valid", 32'(bus.out_valid), 32'd1);
        end
        chk("ops_cnt", 32'(op_cnt), 32'd8);
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_data",  32'(bus.out_data),  32'hF0);

        // Backpressure.
        step(1'b1, 8'hAA, 8'h55, 2, 1'b0, 1'b0, 1'b1);
        chk("bp_first", 32'(bus.out_data), 32'hFF);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h0F, 8'hFF, 0, 1'b0, 1'b0, 1'b0);
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp_hold_data", 32'(bus.out_data), 32'hFF);
            chk("bp_hold_par",  32'(bus.out_par),  32'd0);
            chk("bp_hold_cnt",  32'(op_cnt),       32'd9);
        end
        drive(1'b1, 8'h0F, 8'hFF, 0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_release_data", 32'(bus.out_data), 32'h0F);
        chk("bp_release_cnt",  32'(op_cnt),       32'd10);
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);

        // Accumulator.
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b1);
        chk("acc_clr", 32'(acc), 32'd0);
        step(1'b1, 8'hEE, 8'h01, 1, 1'b1, 1'b0, 1'b1);
        chk("acc_or1", 32'(acc), 32'h01);
        step(1'b1, 8'hEE, 8'h02, 1, 1'b1, 1'b0, 1'b1);
        chk("acc_or2", 32'(acc), 32'h03);
        step(1'b1, 8'hEE, 8'h04, 1, 1'b1, 1'b0, 1'b1);
        chk("acc_or3", 32'(acc), 32'h07);
        step(1'b1, 8'hEE, 8'h00, 3, 1'b1, 1'b0, 1'b1);
        chk("acc_not_data", 32'(bus.out_data), 32'hF8);
        chk("acc_not_zero", 32'(bus.out_zero), 32'd0);
        // Rebuild acc=07, then clear and load in the same cycle.
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hEE, 8'h07, 1, 1'b1, 1'b0, 1'b1);
        chk("acc_rebuild", 32'(acc), 32'h07);
        step(1'b1, 8'hEE, 8'h81, 2, 1'b1, 1'b1, 1'b1);
        chk("simul_data", 32'(bus.out_data), 32'h81);
        chk("simul_acc",  32'(acc),          32'h81);
        // Clear alone leaves a held result untouched.
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0);
        chk("clr_keep_valid", 32'(bus.out_valid), 32'd1);
        chk("clr_keep_data",  32'(bus.out_data),  32'h81);
        chk("clr_only_acc",   32'(acc),           32'd0);
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);

`ifdef LOGIC_UNIT_POPCNT_EN
        step(1'b1, 8'hFF, 8'hB7, 0, 1'b0, 1'b0, 1'b1);
        chk("pop_data", 32'(bus.out_data), 32'hB7);
        chk("pop_val",  32'(bus.out_pop),  32'd6);
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);
`endif

        // Counter wrap on the CNT_W=2 instance, then reset mid-transaction.
        rst_n = 1'b0;
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hEE, 8'h5A, 1, 1'b1, 1'b0, 1'b1);
        end
        chk("wrap_cnt_w", 32'(op_cnt_w), 32'd1);
        chk("wrap_cnt",   32'(op_cnt),   32'd5);
        chk("wrap_acc",   32'(acc),      32'h5A);
        drive(1'b1, 8'hEE, 8'h5A, 1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_acc",   32'(acc),           32'd0);
        chk("mid_rst_cnt",   32'(op_cnt),        32'd0);
        chk("mid_rst_cnt_w", 32'(op_cnt_w),      32'd0);
        chk("mid_rst_zero",  32'(bus.out_zero),  32'd1);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1);

        chk_en = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's fixed-width combinational bitwise gates (AND/OR/XOR/NOT).
- Single block selects one of eight bitwise ops per transaction.
- Valid/ready handshake on input and output; one-deep output register.
- Optional accumulator feedback; running count of accepted operations.
- Sits between operand sources and the datapath result bus.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of accepted-operation counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept this cycle
in_x  in  WIDTH  operand X
in_y  in  WIDTH  operand Y
in_op  in  3  opcode (see Behaviour)
in_acc  in  1  use accumulator in place of X
acc_clr  in  1  clear accumulator
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result
out_zero  out  1  out_data == 0
out_par  out  1  XOR-reduce of out_data
acc  out  WIDTH  accumulator value
op_cnt  out  CNT_W  accepted-op count

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_zero=1, out_par=0, acc=0, op_cnt=0. Reset overrides every other input, mid-transaction included; a pending result is discarded.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT X (Y ignored), 4 NAND, 5 NOR, 6 XNOR, 7 PASS X.
- Accept: in_valid && in_ready.
- in_ready = !out_valid || out_ready, combinational. Allows full throughput at one op per cycle.
- Latency: the result is registered on the accept edge. out_valid rises on the next cycle.
- Operand A: acc when in_acc=1, else in_x. Operand B: in_y.
- out_data, out_zero and out_par update together on accept. They hold stable while out_valid && !out_ready.
- Output drain: when out_valid && out_ready and there is no new accept, out_valid→0. out_data keeps its last value.
- Accumulator load: on accept with in_acc=1, acc ← result. Accepts with in_acc=0 leave acc unchanged.
- acc_clr without an acc-mode accept: acc ← 0 next edge.
- acc_clr in the same cycle as an acc-mode accept: operand A = 0 for that op, and acc ← result. Clear applies first, then load.
- acc_clr does not affect out_valid or out_data.
- op_cnt increments by 1 on every accept and wraps from 2^CNT_W−1 to 0.
- No X-propagation: outputs never depend on in_* when no accept occurs.

Optional Feature:
- Macro LOGIC_UNIT_POPCNT_EN.
- Defined: adds port out_pop, output, width $clog2(WIDTH+1), holding the popcount of the result. It is registered with out_data, and reset value is 0.
- Undefined: port absent; no popcount logic is generated.

Decomposition:
- Package logic_unit_pkg holds:
  - typedef enum logic [2:0] lu_op_e (LU_AND … LU_PASS)
  - function lu_eval(op, a, b) for the combinational result
  - localparam LU_OP_W = 3
- One natural sub-module: logic_unit_core. It is purely combinational (op, a, b → result, zero, parity) and is instantiated once inside logic_unit_pipe. The top level keeps the handshake, accumulator and counter.

Test Plan:
- WIDTH=8. Reset, then send X=0xF0, Y=0x3C through ops 0–7 back-to-back with out_ready=1. Required results, one per cycle at latency 1: 0x30, 0xFC, 0xCC, 0x0F, 0xCF, 0x03, 0x33, 0xF0. op_cnt=8.
- Backpressure: accept X=0xAA, Y=0x55, op XOR, then hold out_ready=0 for 3 cycles with in_valid=1. Required: in_ready=0, out_data stays 0xFF, out_par=0, no extra accept. When out_ready=1, the next op is accepted the same cycle.
- Accumulator: acc_clr, then acc-mode OR with Y=0x01, 0x02, 0x04. Required: acc = 0x01, 0x03, 0x07. Then acc-mode NOT gives 0xF8 and out_zero=0.
- Simultaneous clear: acc=0x07; acc-mode XOR with Y=0x81 and acc_clr=1 in the same cycle. Required: result 0x81, acc=0x81.
- Wrap/reset: CNT_W=2; 5 accepts give op_cnt=1. Assert rst_n=0 while out_valid=1. Required next cycle: out_valid=0, acc=0, op_cnt=0, out_zero=1.
- With LOGIC_UNIT_POPCNT_EN: AND 0xFF,0xB7 gives out_pop=6. Without the macro, elaboration produces no out_pop port.
